// File: rtl/sb_multich_checker.sv
// -----------------------------------------------------------------------------
// sb_multich_checker
// Multi-channel hardware scoreboard. Each of CH channels queues expected
// transactions in its own FIFO. When an actual transaction arrives, the FIFO
// head is popped and compared under cmp_mask. A per-channel watchdog drops a
// head that waits too long. Error results are registered one-cycle pulses.
// The global match/error counters saturate instead of wrapping.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous flush of FIFOs, watchdogs, counters and outputs
//   cmp_mask   1 = bit takes part in the compare (shared by all channels)
//   exp_valid  per-channel push request     exp_ready  per-channel !full
//   exp_data   expected data, channel c at [c*DATA_W +: DATA_W]
//   act_valid  per-channel actual strobe (always accepted)
//   act_data   actual data, same packing as exp_data
//   err_valid  per-channel one-cycle error pulse
//   err_code   per-channel 2-bit code: 01 mismatch, 10 unexpected, 11 timeout
//   err_exp    FIFO head involved in the error (0 for unexpected / no error)
//   match_cnt  saturating count of matches
//   err_cnt    saturating count of errors
//   pending    registered OR of "FIFO non-empty" over all channels
// -----------------------------------------------------------------------------
module sb_multich_checker #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 16,
   parameter int CH      = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic [DATA_W-1:0]    cmp_mask,
   input  logic [CH-1:0]        exp_valid,
   output logic [CH-1:0]        exp_ready,
   input  logic [CH*DATA_W-1:0] exp_data,
   input  logic [CH-1:0]        act_valid,
   input  logic [CH*DATA_W-1:0] act_data,
   output logic [CH-1:0]        err_valid,
   output logic [2*CH-1:0]      err_code,
   output logic [CH*DATA_W-1:0] err_exp,
   output logic [CNT_W-1:0]     match_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 pending
);

   localparam int AW   = $clog2(DEPTH);
   // The watchdog only needs to hold 0 .. TIMEOUT-1: the expiry fires on the
   // cycle the count would reach TIMEOUT, so a head waits exactly TIMEOUT cycles.
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   logic [CH-1:0] match_vec;
   logic [CH-1:0] err_vec;
   logic [CH-1:0] busy_next;

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [AW:0]       wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
      logic [WD_W-1:0]   wd_reg;
      logic              err_valid_reg;
      logic [1:0]        err_code_reg, code_next;
      logic [DATA_W-1:0] err_exp_reg, exp_next;
      logic [DATA_W-1:0] exp_word, act_word, head;
      logic              empty, full, push, act, same, timeout, pop;

      assign exp_word = exp_data[gi*DATA_W +: DATA_W];
      assign act_word = act_data[gi*DATA_W +: DATA_W];

      // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
      assign empty = (wr_ptr_reg == rd_ptr_reg);
      assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      // Head is read asynchronously so the compare happens in the act cycle.
      assign head  = mem[rd_ptr_reg[AW-1:0]];

      assign push    = exp_valid[gi] && !full;
      assign act     = act_valid[gi];
      assign same    = ((head ^ act_word) & cmp_mask) == '0;
      // An actual in the expiry cycle wins, hence the !act term.
      assign timeout = (TIMEOUT != 0) && !empty && !act && (wd_reg == WD_LAST);
      assign pop     = (act && !empty) || timeout;

      assign wr_ptr_next = push ? wr_ptr_reg + (AW+1)'(1) : wr_ptr_reg;
      assign rd_ptr_next = pop  ? rd_ptr_reg + (AW+1)'(1) : rd_ptr_reg;

      always_comb begin
         code_next = 2'b00;
         exp_next  = '0;
         if (act && empty) begin
            code_next = 2'b10;                 // no bypass: a same-cycle push does not count
         end else if (act && !same) begin
            code_next = 2'b01;
            exp_next  = head;
         end else if (timeout) begin
            code_next = 2'b11;
            exp_next  = head;
         end
      end

      assign match_vec[gi] = act && !empty && same;
      assign err_vec[gi]   = (code_next != 2'b00);
      assign busy_next[gi] = (wr_ptr_next != rd_ptr_next);

      // Storage has no reset; the pointers alone define what is valid.
      always_ff @(posedge clk) begin
         if (push && !clear) begin
            mem[wr_ptr_reg[AW-1:0]] <= exp_word;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            wd_reg        <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= 2'b00;
            err_exp_reg   <= '0;
         end else if (clear) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            wd_reg        <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= 2'b00;
            err_exp_reg   <= '0;
         end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            if ((TIMEOUT == 0) || empty || act || pop) begin
               wd_reg <= '0;
            end else begin
               wd_reg <= wd_reg + WD_W'(1);
            end
            err_valid_reg <= (code_next != 2'b00);
            err_code_reg  <= code_next;
            err_exp_reg   <= exp_next;
         end
      end

      assign exp_ready[gi]                  = !full;
      assign err_valid[gi]                  = err_valid_reg;
      assign err_code[2*gi +: 2]            = err_code_reg;
      assign err_exp[gi*DATA_W +: DATA_W]   = err_exp_reg;
   end

   // Global counters: add the number of reporting channels, clamp at all-ones.
   // The extra top bit catches the overflow (CH <= 8, CNT_W >= 4 assumed).
   logic [CNT_W:0]   n_match, n_err, sum_match, sum_err;
   logic [CNT_W-1:0] match_cnt_reg, err_cnt_reg, match_cnt_next, err_cnt_next;
   logic             pending_reg;

   always_comb begin
      n_match = '0;
      n_err   = '0;
      for (int i = 0; i < CH; i++) begin
         n_match = n_match + (CNT_W+1)'(match_vec[i]);
         n_err   = n_err   + (CNT_W+1)'(err_vec[i]);
      end
      sum_match      = {1'b0, match_cnt_reg} + n_match;
      sum_err        = {1'b0, err_cnt_reg}   + n_err;
      match_cnt_next = sum_match[CNT_W] ? '1 : sum_match[CNT_W-1:0];
      err_cnt_next   = sum_err[CNT_W]   ? '1 : sum_err[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt_reg <= '0;
         err_cnt_reg   <= '0;
         pending_reg   <= 1'b0;
      end else if (clear) begin
         match_cnt_reg <= '0;
         err_cnt_reg   <= '0;
         pending_reg   <= 1'b0;
      end else begin
         match_cnt_reg <= match_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         pending_reg   <= |busy_next;
      end
   end

   assign match_cnt = match_cnt_reg;
   assign err_cnt   = err_cnt_reg;
   assign pending   = pending_reg;

endmodule
